// File: rtl/cordic_fmt_pkg.sv
// Shared types and constants for the CORDIC fractional-digit ASCII formatter.
package cordic_fmt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ROM_WAIT  = 2'd1,
    ST_ROM_LATCH = 2'd2,
    ST_SEND      = 2'd3
  } state_e;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned MAX_CHARS  = 10;
  localparam int unsigned IDX_W      = $clog2(MAX_CHARS);

endpackage

// File: rtl/digit_to_ascii.sv
// Binary decimal digit to ASCII; anything outside 0-9 renders as '?'.
module digit_to_ascii
  import cordic_fmt_pkg::*;
(
  input  logic [7:0] digit_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    ascii_o = ASCII_QMARK;
    if (digit_i <= 8'd9) ascii_o = ASCII_ZERO + digit_i;
  end

endmodule

// File: rtl/fraction_ascii_streamer.sv
// Reads six fractional digits from the ROM for a result code and streams
// "0.dddddd" (optionally trimmed / CRLF-terminated) over a valid/ready link.
module fraction_ascii_streamer
  import cordic_fmt_pkg::*;
#(
  parameter bit TRIM_ZEROS  = 1'b0,
  parameter bit APPEND_CRLF = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] code,
  output logic       busy,
  output logic [5:0] rom_addr,
  input  logic [7:0] rom_tenths,
  input  logic [7:0] rom_hundredths,
  input  logic [7:0] rom_thousandths,
  input  logic [7:0] rom_ten_thous,
  input  logic [7:0] rom_hund_thous,
  input  logic [7:0] rom_millionths,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       done
);

  state_e                           state_q, state_d;
  logic [5:0]                       rom_addr_q, rom_addr_d;
  logic [NUM_DIGITS-1:0][7:0]       digits_q, digits_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [IDX_W-1:0]                 ndig_q, ndig_d;

  logic [NUM_DIGITS-1:0][7:0]       rom_dig;
  logic [IDX_W-1:0]                 ndig_cap;
  logic [IDX_W-1:0]                 last_idx;
  logic [IDX_W-1:0]                 dsel;
  logic [7:0]                       digit_sel;
  logic [7:0]                       digit_ascii;
  logic [7:0]                       char_mux;
  logic                             handshake;

  assign rom_dig = {rom_millionths, rom_hund_thous, rom_ten_thous,
                    rom_thousandths, rom_hundredths, rom_tenths};

  // Digit count: 1 + position of the last nonzero digit, floor of one digit
  always_comb begin
    ndig_cap = IDX_W'(NUM_DIGITS);
    if (TRIM_ZEROS) begin
      ndig_cap = IDX_W'(1);
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        if (rom_dig[k] != '0) ndig_cap = IDX_W'(k + 1);
      end
    end
  end

  assign last_idx = ndig_q + (APPEND_CRLF ? IDX_W'(3) : IDX_W'(1));
  assign dsel     = idx_q - IDX_W'(2);

  always_comb begin
    digit_sel = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (dsel == IDX_W'(k)) digit_sel = digits_q[k];
    end
  end

  digit_to_ascii u_digit_to_ascii (
    .digit_i (digit_sel),
    .ascii_o (digit_ascii)
  );

  always_comb begin
    char_mux = ASCII_LF;
    if (idx_q == IDX_W'(0))                char_mux = ASCII_ZERO;
    else if (idx_q == IDX_W'(1))           char_mux = ASCII_DOT;
    else if (idx_q < IDX_W'(2) + ndig_q)   char_mux = digit_ascii;
    else if (idx_q == IDX_W'(2) + ndig_q)  char_mux = ASCII_CR;
  end

  assign out_valid = (state_q == ST_SEND);
  assign out_data  = out_valid ? char_mux : '0;
  assign handshake = out_valid && out_ready;
  assign done      = handshake && (idx_q == last_idx);
  assign busy      = (state_q != ST_IDLE);
  assign rom_addr  = rom_addr_q;

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    digits_d   = digits_q;
    idx_d      = idx_q;
    ndig_d     = ndig_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          rom_addr_d = code;
          state_d    = ST_ROM_WAIT;
        end
      end
      ST_ROM_WAIT: state_d = ST_ROM_LATCH;
      ST_ROM_LATCH: begin
        digits_d = rom_dig;
        ndig_d   = ndig_cap;
        idx_d    = '0;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (handshake) begin
          if (idx_q == last_idx) state_d = ST_IDLE;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rom_addr_q <= '0;
      digits_q   <= '0;
      idx_q      <= '0;
      ndig_q     <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      digits_q   <= digits_d;
      idx_q      <= idx_d;
      ndig_q     <= ndig_d;
    end
  end

endmodule

// File: tb/tb_fraction_ascii_streamer.sv
// Three formatter configurations (plain, trimmed, CRLF) driven in lockstep
// against a registered ROM model and a string-building reference.
module tb_fraction_ascii_streamer;

  typedef logic [7:0] bq_t[$];
  typedef logic [7:0] dig_t[6];

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] code;
  logic       out_ready;

  logic [7:0] od[3];
  logic       ov[3];
  logic       dn[3];
  logic       bs[3];
  logic [5:0] ra[3];
  logic [7:0] rd[3][6];

  logic [7:0] rom_mem[64][6];

  bq_t        capq[3];
  int         dcnt[3];
  int         dpos[3];
  bit         prev_stall[3];
  logic [7:0] prev_d[3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fraction_ascii_streamer #(.TRIM_ZEROS(1'b0), .APPEND_CRLF(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .code(code), .busy(bs[0]), .rom_addr(ra[0]),
    .rom_tenths(rd[0][0]), .rom_hundredths(rd[0][1]), .rom_thousandths(rd[0][2]),
    .rom_ten_thous(rd[0][3]), .rom_hund_thous(rd[0][4]), .rom_millionths(rd[0][5]),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready), .done(dn[0]));

  fraction_ascii_streamer #(.TRIM_ZEROS(1'b1), .APPEND_CRLF(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .code(code), .busy(bs[1]), .rom_addr(ra[1]),
    .rom_tenths(rd[1][0]), .rom_hundredths(rd[1][1]), .rom_thousandths(rd[1][2]),
    .rom_ten_thous(rd[1][3]), .rom_hund_thous(rd[1][4]), .rom_millionths(rd[1][5]),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready), .done(dn[1]));

  fraction_ascii_streamer #(.TRIM_ZEROS(1'b0), .APPEND_CRLF(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .code(code), .busy(bs[2]), .rom_addr(ra[2]),
    .rom_tenths(rd[2][0]), .rom_hundredths(rd[2][1]), .rom_thousandths(rd[2][2]),
    .rom_ten_thous(rd[2][3]), .rom_hund_thous(rd[2][4]), .rom_millionths(rd[2][5]),
    .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready), .done(dn[2]));

  // Synchronous ROM: outputs reflect the address sampled at the previous edge
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 6; k++)
        rd[i][k] <= rom_mem[ra[i]][k];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bq_t model(input dig_t d, input bit trim, input bit crlf);
    bq_t s;
    int  n;
    n = 6;
    if (trim) begin
      n = 1;
      for (int k = 0; k < 6; k++) if (d[k] != 0) n = k + 1;
    end
    s.push_back(8'h30);
    s.push_back(8'h2E);
    for (int k = 0; k < n; k++) s.push_back((d[k] <= 9) ? 8'h30 + d[k] : 8'h3F);
    if (crlf) begin
      s.push_back(8'h0D);
      s.push_back(8'h0A);
    end
    return s;
  endfunction

  // Sampled on the falling edge; inputs only change just after rising edges
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        prev_stall[i] = 1'b0;
      end else begin
        if (prev_stall[i]) begin
          chk($sformatf("hold_valid%0d", i), 32'(ov[i]), 32'd1);
          chk($sformatf("hold_data%0d", i), 32'(od[i]), 32'(prev_d[i]));
        end
        if (ov[i] && out_ready) capq[i].push_back(od[i]);
        if (dn[i]) begin
          dcnt[i] = dcnt[i] + 1;
          dpos[i] = capq[i].size();
        end
        prev_stall[i] = ov[i] && !out_ready;
        prev_d[i]     = od[i];
      end
    end
  end

  task automatic run_string(input logic [5:0] c, input dig_t d, input int pct, input bit hold_start);
    bq_t exp;
    int  cyc;
    for (int k = 0; k < 6; k++) rom_mem[c][k] = d[k];
    for (int i = 0; i < 3; i++) begin
      capq[i].delete();
      dcnt[i] = 0;
      dpos[i] = 0;
    end
    @(posedge clk); #1;
    start = 1'b1; code = c; out_ready = 1'b1;
    @(posedge clk); #1;
    start = hold_start; code = 6'($urandom_range(63));
    chk("rom_addr", 32'(ra[0]), 32'(c));
    chk("busy_after_start", 32'(bs[0]), 32'd1);
    chk("valid_lat1", 32'(ov[0]), 32'd0);
    @(posedge clk); #1;
    chk("valid_lat2", 32'(ov[0]), 32'd0);
    @(posedge clk); #1;
    chk("valid_lat3", 32'(ov[0]), 32'd1);
    // Scribble the ROM entry: the stream must come from the captured snapshot
    for (int k = 0; k < 6; k++) rom_mem[c][k] = d[k] ^ 8'h05;
    cyc = 0;
    while (cyc < 400 && (bs[0] || bs[1] || bs[2])) begin
      start     = hold_start && bs[0];
      out_ready = ($urandom_range(99) < pct);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; out_ready = 1'b1;
    chk("timeout", 32'(cyc >= 400), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      exp = model(d, i == 1, i == 2);
      chk($sformatf("idle%0d", i), 32'(bs[i]), 32'd0);
      chk($sformatf("len%0d", i), 32'(capq[i].size()), 32'(exp.size()));
      for (int j = 0; j < exp.size(); j++) begin
        if (j < capq[i].size())
          chk($sformatf("byte%0d[%0d]", i, j), 32'(capq[i][j]), 32'(exp[j]));
      end
      chk($sformatf("done_cnt%0d", i), 32'(dcnt[i]), 32'd1);
      chk($sformatf("done_pos%0d", i), 32'(dpos[i]), 32'(exp.size()));
    end
  endtask

  initial begin
    dig_t d;
    int   cyc;
    for (int a = 0; a < 64; a++) for (int k = 0; k < 6; k++) rom_mem[a][k] = 8'h00;
    rst = 1'b1; start = 1'b0; code = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_valid%0d", i), 32'(ov[i]), 32'd0);
      chk($sformatf("rst_busy%0d", i), 32'(bs[i]), 32'd0);
      chk($sformatf("rst_addr%0d", i), 32'(ra[i]), 32'd0);
      chk($sformatf("rst_data%0d", i), 32'(od[i]), 32'd0);
      chk($sformatf("rst_done%0d", i), 32'(dn[i]), 32'd0);
    end
    rst = 1'b0;

    d = '{8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2};
    run_string(6'd5, d, 100, 1'b0);
    run_string(6'd5, d, 50, 1'b0);

    d = '{8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run_string(6'd12, d, 70, 1'b0);
    d = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run_string(6'd0, d, 70, 1'b0);
    d = '{8'd0, 8'd0, 8'd7, 8'd0, 8'd0, 8'd0};
    run_string(6'd63, d, 70, 1'b0);
    d = '{8'd0, 8'd0, 8'd0, 8'h0C, 8'd0, 8'd0};
    run_string(6'd33, d, 60, 1'b0);

    // start held high through SEND and the done cycle, then a fresh string
    d = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9};
    run_string(6'd21, d, 100, 1'b1);
    d = '{8'd2, 8'd7, 8'd1, 8'd8, 8'd2, 8'd8};
    run_string(6'd22, d, 100, 1'b0);

    for (int r = 0; r < 8; r++) begin
      int tz;
      for (int k = 0; k < 6; k++)
        d[k] = ($urandom_range(9) == 0) ? 8'($urandom_range(10, 255)) : 8'($urandom_range(9));
      tz = $urandom_range(6);
      for (int k = 6 - tz; k < 6; k++) d[k] = 8'd0;
      run_string(6'($urandom_range(63)), d, $urandom_range(50, 100), 1'b0);
    end

    // Asynchronous reset while the fourth byte is on the link
    d = '{8'd6, 8'd6, 8'd6, 8'd6, 8'd6, 8'd6};
    for (int k = 0; k < 6; k++) rom_mem[6'd40][k] = d[k];
    for (int i = 0; i < 3; i++) capq[i].delete();
    @(posedge clk); #1;
    start = 1'b1; code = 6'd40; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (cyc < 100 && capq[0].size() < 3) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rst_wait_timeout", 32'(cyc >= 100), 32'd0);
    chk("mid_valid", 32'(ov[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort_valid%0d", i), 32'(ov[i]), 32'd0);
      chk($sformatf("abort_busy%0d", i), 32'(bs[i]), 32'd0);
      chk($sformatf("abort_addr%0d", i), 32'(ra[i]), 32'd0);
      chk($sformatf("abort_done%0d", i), 32'(dn[i]), 32'd0);
    end
    #2 rst = 1'b0;
    d = '{8'd8, 8'd0, 8'd2, 8'd0, 8'd9, 8'd0};
    run_string(6'd9, d, 60, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
